bcd_to_binary_seq: RTL and testbench

//  Sequential BCD-to-binary converter; the inverse of the combinational binary-to-BCD block.

---
 rtl/bcd_to_binary_seq.sv | 134 +++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble, one bit per clock).
// Optional range/digit checking is compiled in with `define BCD_RANGE_CHECK_EN.
module bcd_to_binary_seq #(
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       START,
  input  logic [3:0] ONES,
  input  logic [3:0] TENS,
  input  logic [1:0] HUNDREDS,
  output logic [7:0] BIN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  bcd_q, bcd_d;
  logic [9:0]  bin_q, bin_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  res_q, res_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        load;
  logic        last;
  logic [9:0]  bcd_sh;
`ifdef BCD_RANGE_CHECK_EN
  logic        bad_q, bad_d;
`endif

  assign load = START && (state_q == IDLE || state_q == FIN);
  // Ten shifts happen with cnt 0..9; the edge seen with cnt==10 only publishes the result.
  assign last = (cnt_q == 4'd10);

  // Undo the add-3: any nibble that picked up a bit from above (>=8) loses 3.
  always_comb begin
    bcd_sh = {1'b0, bcd_q[9:1]};
    if (bcd_sh[7:4] >= 4'd8) bcd_sh[7:4] = bcd_sh[7:4] - 4'd3;
    if (bcd_sh[3:0] >= 4'd8) bcd_sh[3:0] = bcd_sh[3:0] - 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = SHIFT;
      SHIFT:   if (last)  state_d = FIN;
      FIN:     if (START) state_d = SHIFT;
               else if (DONE_PULSE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
`ifdef BCD_RANGE_CHECK_EN
    bad_d  = bad_q;
`endif
    if (load) begin
      bcd_d  = {HUNDREDS, TENS, ONES};
      bin_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
`ifdef BCD_RANGE_CHECK_EN
      bad_d  = (TENS > 4'd9) || (ONES > 4'd9);
`endif
    end else if (state_q == SHIFT) begin
      if (last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
`ifdef BCD_RANGE_CHECK_EN
        err_d  = bad_q || (bin_q[9:8] != 2'b00);
        res_d  = err_d ? 8'hFF : bin_q[7:0];
`else
        err_d  = 1'b0;
        res_d  = bin_q[7:0];
`endif
      end else begin
        bcd_d = bcd_sh;
        bin_d = {bcd_q[0], bin_q[9:1]};
        cnt_d = cnt_q + 4'd1;
      end
    end else if (state_q == FIN && DONE_PULSE) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef BCD_RANGE_CHECK_EN
      bad_q  <= 1'b0;
`endif
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
`ifdef BCD_RANGE_CHECK_EN
      bad_q  <= bad_d;
`endif
    end
  end

  assign BIN  = res_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench: two converters (pulsed and held DONE) share stimulus; monitors pop expected results.
module tb_bcd_to_binary_seq;

  typedef struct packed { logic [7:0] bin; logic err; } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] ones, tens;
  logic [1:0] hund;
  logic [7:0] p_bin, h_bin;
  logic       p_busy, p_done, p_err;
  logic       h_busy, h_done, h_err;
  logic       p_done_prev = 1'b0;
  logic       h_done_prev = 1'b0;

  exp_t qp[$];
  exp_t qh[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq #(.DONE_PULSE(1'b1)) u_p (
    .clk(clk), .reset(rst), .START(start), .ONES(ones), .TENS(tens), .HUNDREDS(hund),
    .BIN(p_bin), .BUSY(p_busy), .DONE(p_done), .ERR(p_err));

  bcd_to_binary_seq #(.DONE_PULSE(1'b0)) u_h (
    .clk(clk), .reset(rst), .START(start), .ONES(ones), .TENS(tens), .HUNDREDS(hund),
    .BIN(h_bin), .BUSY(h_busy), .DONE(h_done), .ERR(h_err));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulsed instance: every DONE sample is a fresh result and must not follow a DONE sample.
  always @(negedge clk) begin
    if (!rst && p_done) begin
      exp_t e;
      chk("p_done_width", int'(p_done_prev), 0);
      if (qp.size() == 0) begin
        errors++; checks++;
        $display("FAIL p_spurious_done: got BIN=%0h with no expected result", p_bin);
      end else begin
        e = qp.pop_front();
        chk("p_bin", int'(p_bin), int'(e.bin));
        chk("p_err", int'(p_err), int'(e.err));
      end
    end
    p_done_prev = p_done;
  end

  always @(negedge clk) begin
    if (!rst && h_done && !h_done_prev) begin
      exp_t e;
      if (qh.size() == 0) begin
        errors++; checks++;
        $display("FAIL h_spurious_done: got BIN=%0h with no expected result", h_bin);
      end else begin
        e = qh.pop_front();
        chk("h_bin", int'(h_bin), int'(e.bin));
        chk("h_err", int'(h_err), int'(e.err));
      end
    end
    h_done_prev = h_done;
  end

  // Pick the hand-computed expectation for the build configuration.
  function automatic exp_t pick(input logic [7:0] bn, input logic en,
                                input logic [7:0] bc, input logic ec);
    exp_t e;
`ifdef BCD_RANGE_CHECK_EN
    e.bin = bc; e.err = ec;
`else
    e.bin = bn; e.err = en;
`endif
    return e;
  endfunction

  // Issue START for one edge; expectation goes to both scoreboards when push=1.
  task automatic issue(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                       input exp_t e, input bit push);
    hund = h; tens = t; ones = o; start = 1'b1;
    if (push) begin qp.push_back(e); qh.push_back(e); end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!p_done && n < 40);
    if (!p_done) begin
      errors++; checks++;
      $display("FAIL done_timeout: got DONE=0 expected 1 within 40 cycles");
    end
  endtask

  task automatic convert(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                         input exp_t e);
    issue(h, t, o, e, 1'b1);
    wait_done();
  endtask

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; hund = '0; tens = '0; ones = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_bin", int'(p_bin), 0);
    chk("rst_p_busy", int'(p_busy), 0);
    chk("rst_p_done", int'(p_done), 0);
    chk("rst_p_err", int'(p_err), 0);
    chk("rst_h_done", int'(h_done), 0);
    rst = 1'b0;
    @(negedge clk);

    // 255: BUSY after E0..E10, DONE after E11
    issue(2'd2, 4'd5, 4'd5, pick(8'hFF, 1'b0, 8'hFF, 1'b0), 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (!p_busy || p_done) ok = 1'b0;
      if (i < 10) begin @(posedge clk); #1; end
    end
    chk("busy_e0_e10", int'(ok), 1);
    @(posedge clk); #1;
    chk("done_e11", int'(p_done), 1);
    chk("busy_e11", int'(p_busy), 0);
    @(negedge clk);

    convert(2'd1, 4'd2, 4'd8, pick(8'h80, 1'b0, 8'h80, 1'b0));
    convert(2'd0, 4'd0, 4'd0, pick(8'h00, 1'b0, 8'h00, 1'b0));
    convert(2'd0, 4'd0, 4'd9, pick(8'h09, 1'b0, 8'h09, 1'b0));
    convert(2'd3, 4'd0, 4'd0, pick(8'h2C, 1'b0, 8'hFF, 1'b1));
    convert(2'd3, 4'd9, 4'd9, pick(8'h8F, 1'b0, 8'hFF, 1'b1));
    convert(2'd2, 4'd5, 4'd6, pick(8'h00, 1'b0, 8'hFF, 1'b1));
`ifdef BCD_RANGE_CHECK_EN
    convert(2'd0, 4'hA, 4'd0, pick(8'h00, 1'b0, 8'hFF, 1'b1));
`endif

    // START re-pulsed at E3 with other digits must be ignored
    issue(2'd1, 4'd2, 4'd8, pick(8'h80, 1'b0, 8'h80, 1'b0), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    issue(2'd3, 4'd9, 4'd9, pick(8'h00, 1'b0, 8'h00, 1'b0), 1'b0);
    wait_done();

    // Held DONE: 20 cycles with no START; pulsed DONE must have dropped
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!h_done || h_bin !== 8'h80 || p_done) ok = 1'b0;
    end
    chk("hold_20_cycles", int'(ok), 1);
    chk("p_bin_kept", int'(p_bin), 8'h80);

    // Back-to-back from DONE: 99 then 123
    convert(2'd0, 4'd9, 4'd9, pick(8'h63, 1'b0, 8'h63, 1'b0));
    issue(2'd1, 4'd2, 4'd3, pick(8'h7B, 1'b0, 8'h7B, 1'b0), 1'b1);
    chk("h_done_drop_on_start", int'(h_done), 0);
    chk("h_busy_on_start", int'(h_busy), 1);
    wait_done();

    // Reset at E5 aborts; no DONE may follow
    @(negedge clk);
    issue(2'd0, 4'd9, 4'd9, pick(8'h00, 1'b0, 8'h00, 1'b0), 1'b0);
    repeat (4) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_p_busy", int'(p_busy), 0);
    chk("abort_p_done", int'(p_done), 0);
    chk("abort_p_bin", int'(p_bin), 0);
    chk("abort_h_done", int'(h_done), 0);
    chk("abort_h_bin", int'(h_bin), 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);

    chk("qp_empty", qp.size(), 0);
    chk("qh_empty", qh.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
